uart_tx_fifo: RTL and testbench



---
 rtl/uart_tx_fifo.sv | 136 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//
// Transmit-side character buffer that sits in front of the UART controller's Tx
// path. The host writes characters through a valid/ready port. The buffer then
// hands them to the controller one at a time over tx_start/tx_data. It moves on
// to the next character only after the controller pulses tx_done.
//
// Handshake rule (write port): a character is transferred on a rising clk_i
// edge where wr_valid_i && wr_ready_o. wr_ready_o depends only on registered
// occupancy. While wr_ready_o is low, the host must hold wr_valid_i and
// wr_data_i. A write attempted while full is not a transfer, and its data is
// dropped. A write on the same edge as flush_i is discarded.
//
// Ports
//   clk_i        in   clock, rising-edge active
//   rst_i        in   asynchronous reset, active low
//   wr_valid_i   in   host presents a character
//   wr_data_i    in   character to enqueue
//   wr_ready_o   out  buffer can accept a character (not full)
//   flush_i      in   synchronous clear of contents and drain state
//   drain_en_i   in   permits new characters to be issued
//   tx_busy_i    in   controller transmitter busy
//   tx_done_i    in   controller transmit-complete pulse
//   tx_start_o   out  one-cycle start pulse to the controller
//   tx_data_o    out  character in flight, held from issue until done
//   count_o      out  current occupancy
//   empty_o      out  occupancy is zero
//   full_o       out  occupancy equals FIFO_DEPTH
//   state_o      out  drain FSM state (0 IDLE, 1 ISSUE, 2 WAIT_DONE)
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
   parameter int MAX_UART_DATA_W = 8,
   parameter int FIFO_DEPTH      = 16
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic                                 wr_valid_i,
   input  logic [MAX_UART_DATA_W-1:0]           wr_data_i,
   output logic                                 wr_ready_o,
   input  logic                                 flush_i,
   input  logic                                 drain_en_i,
   input  logic                                 tx_busy_i,
   input  logic                                 tx_done_i,
   output logic                                 tx_start_o,
   output logic [MAX_UART_DATA_W-1:0]           tx_data_o,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]      count_o,
   output logic                                 empty_o,
   output logic                                 full_o,
   output logic [1:0]                           state_o
);

   localparam int AddrWidth  = $clog2(FIFO_DEPTH);
   localparam int CountWidth = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_DONE = 2'd2
   } state_t;

   state_t                       state_q;
   state_t                       state_d;
   logic [MAX_UART_DATA_W-1:0]   mem [FIFO_DEPTH];
   logic [AddrWidth-1:0]         wr_ptr_q;
   logic [AddrWidth-1:0]         rd_ptr_q;
   logic [CountWidth-1:0]        count_q;
   logic [MAX_UART_DATA_W-1:0]   tx_data_q;
   logic                         push;
   logic                         pop;

   // Every output is a register or a decode of registers, so no input
   // reaches an output combinationally.
   assign full_o     = (count_q == CountWidth'(FIFO_DEPTH));
   assign empty_o    = (count_q == '0);
   assign wr_ready_o = !full_o;
   assign count_o    = count_q;
   assign tx_start_o = (state_q == ISSUE);
   assign tx_data_o  = tx_data_q;
   assign state_o    = state_q;

   // flush_i wins over both push and pop on the same edge.
   assign push = wr_valid_i && !full_o && !flush_i;
   assign pop  = (state_q == IDLE) && !empty_o && drain_en_i && !tx_busy_i && !flush_i;

   // Drain FSM: next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:      if (pop) state_d = ISSUE;
         ISSUE:     state_d = WAIT_DONE;
         WAIT_DONE: if (tx_done_i) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
      if (flush_i) state_d = IDLE;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Pointers, occupancy and the character in flight
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         tx_data_q <= '0;
      end else if (flush_i) begin
         // tx_data_q keeps its value. A character already handed to the
         // controller is not withdrawn.
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop) begin
            rd_ptr_q  <= rd_ptr_q + 1'b1;
            tx_data_q <= mem[rd_ptr_q];
         end
         unique case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage array. It is not reset, because an entry is only read after it
   // has been written.
   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr_q] <= wr_data_i;
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Bench for uart_tx_fifo. A queue-based reference model tracks the buffer
// contents, the character in flight and the transmit phase. A small
// controller emulator answers each start pulse with busy and then a one-cycle
// done pulse.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

   localparam int W     = 8;
   localparam int DEPTH = 16;
   localparam int CW    = $clog2(DEPTH + 1);

   logic          clk_i;
   logic          rst_i;
   logic          wr_valid_i;
   logic [W-1:0]  wr_data_i;
   logic          wr_ready_o;
   logic          flush_i;
   logic          drain_en_i;
   logic          tx_busy_i;
   logic          tx_done_i;
   logic          tx_start_o;
   logic [W-1:0]  tx_data_o;
   logic [CW-1:0] count_o;
   logic          empty_o;
   logic          full_o;
   logic [1:0]    state_o;

   int errors = 0;
   int checks = 0;

   uart_tx_fifo #(.MAX_UART_DATA_W(W), .FIFO_DEPTH(DEPTH)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .wr_valid_i (wr_valid_i),
      .wr_data_i  (wr_data_i),
      .wr_ready_o (wr_ready_o),
      .flush_i    (flush_i),
      .drain_en_i (drain_en_i),
      .tx_busy_i  (tx_busy_i),
      .tx_done_i  (tx_done_i),
      .tx_start_o (tx_start_o),
      .tx_data_o  (tx_data_o),
      .count_o    (count_o),
      .empty_o    (empty_o),
      .full_o     (full_o),
      .state_o    (state_o)
   );

   // ---------------- clock / reset ----------------
   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // ---------------- checking task ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // phase: 0 = nothing being issued, 1 = start-pulse cycle, 2 = waiting done
   logic [W-1:0] model_q[$];
   logic [W-1:0] m_data;
   int           m_phase;

   always @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         model_q.delete();
         m_data  = '0;
         m_phase = 0;
      end else if (flush_i) begin
         model_q.delete();
         m_phase = 0;
      end else begin
         automatic bit do_pop  = (m_phase == 0) && (model_q.size() > 0) && drain_en_i && !tx_busy_i;
         automatic bit do_push = wr_valid_i && (model_q.size() < DEPTH);
         automatic int nxt     = m_phase;
         if (m_phase == 1) nxt = 2;
         else if (m_phase == 2 && tx_done_i) nxt = 0;
         if (do_pop) begin
            m_data = model_q.pop_front();
            nxt    = 1;
         end
         if (do_push) model_q.push_back(wr_data_i);
         m_phase = nxt;
      end
   end

   // ---------------- scoreboard / monitor ----------------
   logic [W-1:0] got_q[$];
   logic [W-1:0] exp_q[$];

   always @(negedge clk_i) begin
      if (rst_i) begin
         check("count",     32'(count_o),   32'(model_q.size()));
         check("empty",     32'(empty_o),   32'(model_q.size() == 0));
         check("full",      32'(full_o),    32'(model_q.size() == DEPTH));
         check("wr_ready",  32'(wr_ready_o), 32'(model_q.size() != DEPTH));
         check("tx_start",  32'(tx_start_o), 32'(m_phase == 1));
         check("tx_data",   32'(tx_data_o), 32'(m_data));
         check("count_max", 32'(count_o <= DEPTH), 32'd1);
         if (tx_start_o) got_q.push_back(tx_data_o);
      end
   end

   // ---------------- controller emulator ----------------
   int ctl_delay  = 5;
   bit rand_delay = 1'b0;

   always begin
      @(negedge clk_i);
      if (tx_start_o && rst_i) begin
         automatic int d = rand_delay ? int'($urandom_range(10, 200)) : ctl_delay;
         tx_busy_i = 1'b1;
         repeat (d) @(negedge clk_i);
         tx_done_i = 1'b1;
         @(negedge clk_i);
         tx_done_i = 1'b0;
         tx_busy_i = 1'b0;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic push(input logic [W-1:0] d);
      @(negedge clk_i);
      wr_valid_i = 1'b1;
      wr_data_i  = d;
      @(negedge clk_i);
      wr_valid_i = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int limit);
      int n = 0;
      while ((model_q.size() != 0 || m_phase != 0 || tx_busy_i) && n < limit) begin
         @(negedge clk_i);
         n++;
      end
      if (n >= limit) check({tag, "_timeout"}, 32'd0, 32'd1);
      repeat (3) @(negedge clk_i);
   endtask

   task automatic compare_seq(input string tag);
      check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check({tag, "_char"}, 32'(got_q[i]), 32'(exp_q[i]));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_i      = 1'b0;
      wr_valid_i = 1'b0;
      wr_data_i  = '0;
      flush_i    = 1'b0;
      drain_en_i = 1'b0;
      tx_busy_i  = 1'b0;
      tx_done_i  = 1'b0;

      // Reset values
      #12;
      check("rst_ready", 32'(wr_ready_o), 32'd1);
      check("rst_start", 32'(tx_start_o), 32'd0);
      check("rst_data",  32'(tx_data_o),  32'd0);
      check("rst_count", 32'(count_o),    32'd0);
      check("rst_empty", 32'(empty_o),    32'd1);
      check("rst_full",  32'(full_o),     32'd0);
      check("rst_state", 32'(state_o),    32'd0);
      @(negedge clk_i);
      rst_i = 1'b1;

      // Single character: start two edges after the push edge
      drain_en_i = 1'b1;
      ctl_delay  = 5;
      got_q.delete();
      push(8'hA5);
      check("single_start_k",  32'(tx_start_o), 32'd0);
      check("single_count_k",  32'(count_o),    32'd1);
      @(negedge clk_i);
      check("single_start_k1", 32'(tx_start_o), 32'd1);
      check("single_data_k1",  32'(tx_data_o),  32'hA5);
      @(negedge clk_i);
      check("single_start_k2", 32'(tx_start_o), 32'd0);
      check("single_state_k2", 32'(state_o),    32'd2);
      wait_idle("single", 500);
      check("single_hold", 32'(tx_data_o), 32'hA5);
      check("single_cnt0", 32'(count_o),   32'd0);
      exp_q = '{8'hA5};
      compare_seq("single");

      // Burst fill with drain disabled, then drain in order
      drain_en_i = 1'b0;
      ctl_delay  = 12;
      got_q.delete();
      exp_q.delete();
      for (int i = 0; i < DEPTH; i++) begin
         push(W'(i));
         exp_q.push_back(W'(i));
      end
      check("burst_full",  32'(full_o),     32'd1);
      check("burst_ready", 32'(wr_ready_o), 32'd0);
      push(8'hEE);
      check("burst_17th",  32'(count_o),    32'(DEPTH));
      drain_en_i = 1'b1;
      wait_idle("burst", 2000);
      compare_seq("burst");

      // Simultaneous push and pop with three queued
      drain_en_i = 1'b0;
      ctl_delay  = 4;
      got_q.delete();
      exp_q = '{8'h31, 8'h32, 8'h33, 8'h34};
      push(8'h31);
      push(8'h32);
      push(8'h33);
      @(negedge clk_i);
      drain_en_i = 1'b1;
      wr_valid_i = 1'b1;
      wr_data_i  = 8'h34;
      @(negedge clk_i);
      wr_valid_i = 1'b0;
      check("simul_count", 32'(count_o),    32'd3);
      check("simul_start", 32'(tx_start_o), 32'd1);
      wait_idle("simul", 500);
      compare_seq("simul");

      // Flush with one in flight, two queued, and a coincident push
      ctl_delay = 40;
      got_q.delete();
      push(8'h11);
      push(8'h22);
      push(8'h33);
      @(negedge clk_i);
      flush_i    = 1'b1;
      wr_valid_i = 1'b1;
      wr_data_i  = 8'h44;
      @(negedge clk_i);
      flush_i    = 1'b0;
      wr_valid_i = 1'b0;
      check("flush_count", 32'(count_o),   32'd0);
      check("flush_empty", 32'(empty_o),   32'd1);
      check("flush_state", 32'(state_o),   32'd0);
      check("flush_data",  32'(tx_data_o), 32'h11);
      wait_idle("flush_done", 500);
      check("flush_no_start", 32'(got_q.size()), 32'd1);
      push(8'h55);
      wait_idle("flush", 500);
      exp_q = '{8'h11, 8'h55};
      compare_seq("flush");

      // Wrap-around with random gaps and random completion delay
      rand_delay = 1'b1;
      got_q.delete();
      exp_q.delete();
      for (int i = 0; i < 40; i++) begin
         automatic logic [W-1:0] d = W'($urandom);
         automatic int gap = int'($urandom_range(0, 150));
         repeat (gap) @(negedge clk_i);
         while (model_q.size() >= DEPTH) @(negedge clk_i);
         push(d);
         exp_q.push_back(d);
      end
      wait_idle("wrap", 30000);
      compare_seq("wrap");
      rand_delay = 1'b0;

      // Asynchronous reset while waiting for done
      ctl_delay = 30;
      got_q.delete();
      push(8'h77);
      begin
         int n = 0;
         while (!tx_start_o && n < 50) begin
            @(negedge clk_i);
            n++;
         end
         if (n >= 50) check("arst_start_timeout", 32'd0, 32'd1);
      end
      @(negedge clk_i);
      check("arst_pre_state", 32'(state_o), 32'd2);
      #2;
      rst_i = 1'b0;
      #1;
      check("arst_ready", 32'(wr_ready_o), 32'd1);
      check("arst_start", 32'(tx_start_o), 32'd0);
      check("arst_data",  32'(tx_data_o),  32'd0);
      check("arst_count", 32'(count_o),    32'd0);
      check("arst_empty", 32'(empty_o),    32'd1);
      check("arst_full",  32'(full_o),     32'd0);
      check("arst_state", 32'(state_o),    32'd0);
      @(negedge clk_i);
      rst_i = 1'b1;
      got_q.delete();
      repeat (60) @(negedge clk_i);
      check("arst_no_issue", 32'(got_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
